// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and baud divider helper
//   rx_state_t : receiver FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   DATA_BITS  : payload bits per frame
//   OVERSAMPLE : ticks per bit
//   calc_div   : clock cycles per oversample tick, truncated
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running oversample tick generator, shareable by rx and tx
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   tick  out one-clk pulse every DIV clocks
module baud_tick_gen
    import uart_pkg::calc_div;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_wrap;
    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign tick   = r_tick;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_tick <= w_wrap;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, 16x oversampled mid-bit sampling
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   rxd       in   asynchronous serial line, idles high
//   rx_data   out  last correctly received byte
//   rx_done   out  one-clk strobe, rx_data just updated
//   rx_busy   out  high while a frame is in progress
//   frame_err out  one-clk strobe, stop bit low and byte discarded
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
);
    rx_state_t            r_state, w_next;
    logic                 r_sync1, r_sync2, r_prev;
    logic [3:0]           r_tick_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic                 r_done, r_ferr, r_busy;
    logic                 w_tick, w_fall, w_mid, w_end, w_done, w_ferr;

    baud_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (w_tick)
    );

    // edge-based start: a line held low cannot retrigger
    assign w_fall = r_prev & ~r_sync2;
    assign w_mid  = w_tick && (r_tick_cnt == 4'd7);
    assign w_end  = w_tick && (r_tick_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = w_fall ? START : IDLE;
            START: w_next = w_mid ? (r_sync2 ? IDLE : DATA) : START;
            DATA:  w_next = (w_end && r_bit_cnt == 3'd7) ? STOP : DATA;
            STOP:  w_next = w_end ? IDLE : STOP;
        endcase
    end

    always_comb begin
        w_done = (r_state == STOP) && w_end && r_sync2;
        w_ferr = (r_state == STOP) && w_end && !r_sync2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_done  <= w_done;
            r_ferr  <= w_ferr;
            // registered from next state so busy drops together with the strobes
            r_busy  <= (w_next != IDLE);
            if (w_done) r_data <= r_shift;
            // restart the tick count at the edge and again at mid start bit,
            // so every later wrap of 15 lands mid-bit
            if (r_state == IDLE || (r_state == START && w_mid)) r_tick_cnt <= '0;
            else if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_state == START) r_bit_cnt <= '0;
            else if (r_state == DATA && w_end) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_state == DATA && w_end) r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
        end
    end

    assign rx_data   = r_data;
    assign rx_done   = r_done;
    assign rx_busy   = r_busy;
    assign frame_err = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at DIV=4 (64 clk per bit)
module tb_uart_rx;
    localparam int BIT = 64;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, rx_busy, frame_err;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_done = 0;
    int         n_ferr = 0;
    int         d0, f0;
    bit         busy_seen = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] got[$];

    uart_rx #(
        .CLK_FREQ(100_000_000),
        .BAUD    (1_562_500)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v, input int bt);
        rxd = 1'b0;
        wait_clk(bt);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clk(bt);
        end
        rxd = stop_v;
        wait_clk(bt);
    endtask

    task automatic mark;
        d0 = n_done;
        f0 = n_ferr;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_busy) busy_seen = 1;
            if (rx_done) begin
                n_done++;
                got.push_back(rx_data);
                check("busy_low_at_done", rx_busy, 0);
                check("busy_high_before_done", prev_busy, 1);
            end
            if (frame_err) n_ferr++;
            if (rx_done || frame_err) check("strobes_exclusive", rx_done & frame_err, 0);
        end
        prev_busy = rx_busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        wait_clk(3);
        check("rst_data", rx_data, 0);
        check("rst_done", rx_done, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_ferr", frame_err, 0);
        reset = 1'b0;
        wait_clk(20);

        // good frame A3
        mark();
        send(8'hA3, 1'b1, BIT);
        wait_clk(BIT);
        check("t1_done_cnt", n_done - d0, 1);
        check("t1_ferr_cnt", n_ferr - f0, 0);
        check("t1_data", rx_data, 8'hA3);
        check("t1_busy_idle", rx_busy, 0);

        // bad stop bit, line held low, then recovery with 3C
        mark();
        send(8'h55, 1'b0, BIT);
        wait_clk(3 * BIT);
        rxd = 1'b1;
        wait_clk(2 * BIT);
        check("t4_ferr_cnt", n_ferr - f0, 1);
        check("t4_done_cnt", n_done - d0, 0);
        check("t4_data_kept", rx_data, 8'hA3);
        check("t4_busy_idle", rx_busy, 0);
        mark();
        send(8'h3C, 1'b1, BIT);
        wait_clk(BIT);
        check("t4_done_3c", n_done - d0, 1);
        check("t4_data_3c", rx_data, 8'h3C);

        // back-to-back 00 then FF
        mark();
        got.delete();
        send(8'h00, 1'b1, BIT);
        send(8'hFF, 1'b1, BIT);
        wait_clk(BIT);
        check("t2_done_cnt", n_done - d0, 2);
        check("t2_ferr_cnt", n_ferr - f0, 0);
        check("t2_first", (got.size() > 0) ? got[0] : 8'hXX, 8'h00);
        check("t2_second", (got.size() > 1) ? got[1] : 8'hXX, 8'hFF);
        check("t2_data", rx_data, 8'hFF);

        // 8-clk glitch rejected before the 9th tick
        mark();
        busy_seen = 0;
        rxd = 1'b0;
        wait_clk(8);
        rxd = 1'b1;
        wait_clk(48);
        check("t3_busy_seen", busy_seen, 1);
        check("t3_busy_back", rx_busy, 0);
        wait_clk(2 * BIT);
        check("t3_done_cnt", n_done - d0, 0);
        check("t3_ferr_cnt", n_ferr - f0, 0);

        // reset in data bit 4; bits 4..7 high so no new edge follows
        mark();
        rxd = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) wait_clk(BIT);
        rxd = 1'b1;
        wait_clk(32);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        check("t5_rst_data", rx_data, 0);
        check("t5_rst_done", rx_done, 0);
        check("t5_rst_busy", rx_busy, 0);
        check("t5_rst_ferr", frame_err, 0);
        wait_clk(32 + 3 * BIT + 2 * BIT);
        check("t5_no_done", n_done - d0, 0);
        check("t5_no_ferr", n_ferr - f0, 0);
        mark();
        send(8'hC5, 1'b1, BIT);
        wait_clk(BIT);
        check("t5_done_c5", n_done - d0, 1);
        check("t5_data_c5", rx_data, 8'hC5);

        // slightly fast transmitter (63 clk per bit)
        mark();
        send(8'hA3, 1'b1, 63);
        wait_clk(BIT);
        check("t6_done_cnt", n_done - d0, 1);
        check("t6_ferr_cnt", n_ferr - f0, 0);
        check("t6_data", rx_data, 8'hA3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
